// File: rtl/boton_acondicionador_pkg.sv
// rtl/boton_acondicionador_pkg.sv - shared types and constants for the button conditioner
// Purpose: per-button FSM state enum, button index constants, arbiter priority
//          order and the one-hot grant helper used by the top-level arbiter.
// Ports:   none (package).
package boton_acondicionador_pkg;

  typedef enum logic [1:0] {
    ARM     = 2'd0,
    IDLE    = 2'd1,
    PRESSED = 2'd2
  } btn_state_t;

  localparam int NUM_BOTONES = 5;
  localparam int IDX_ARRIBA  = 0;
  localparam int IDX_ABAJO   = 1;
  localparam int IDX_IZQ     = 2;
  localparam int IDX_DER     = 3;
  localparam int IDX_ELIGE   = 4;

  // Button indices in priority order, 3 bits per slot; slot 0 is served first.
  localparam logic [14:0] PRIO_ORDER = {3'(IDX_DER), 3'(IDX_IZQ), 3'(IDX_ABAJO),
                                        3'(IDX_ARRIBA), 3'(IDX_ELIGE)};

  // One-hot of the highest-priority pending bit. Walks from the lowest
  // priority slot upward so the last match (highest priority) wins.
  function automatic logic [4:0] grant_of(input logic [4:0] pending);
    logic [4:0] g;
    logic [2:0] idx;
    g = '0;
    for (int k = NUM_BOTONES - 1; k >= 0; k--) begin
      idx = PRIO_ORDER[k*3 +: 3];
      if (pending[idx]) g = 5'b00001 << idx;
    end
    return g;
  endfunction

endpackage

// File: rtl/boton_debounce_fsm.sv
// rtl/boton_debounce_fsm.sv - synchronizer, debouncer and press FSM for one button
// Purpose: turns one raw bouncing button into a debounced level and a
//          registered one-cycle press event. Build macro: AUTOREPEAT_EN adds
//          repeat events while the button stays PRESSED (if REPEAT_ALLOWED).
// Ports:   clk, reset (async, active-high), boton (raw input),
//          nivel (debounced level), press (one-cycle press event).
import boton_acondicionador_pkg::*;

module boton_debounce_fsm #(
  parameter int DEBOUNCE_CYCLES     = 1000000,
  parameter int REPEAT_DELAY_CYCLES = 50000000,
  parameter int REPEAT_RATE_CYCLES  = 15000000,
  parameter bit REPEAT_ALLOWED      = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic boton,
  output logic nivel,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1, sync2;
  btn_state_t       state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             match, hit, rep_hit, press_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= boton;
      sync2 <= sync1;
    end
  end

  // IDLE waits for a stable high; ARM and PRESSED both wait for a stable low.
  always_comb begin
    match = (state == IDLE) ? sync2 : ~sync2;
    hit   = match && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ARM;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ARM:     if (hit) state_next = IDLE;
      IDLE:    if (hit) state_next = PRESSED;
      PRESSED: if (hit) state_next = IDLE;
      default: state_next = ARM;
    endcase
  end

  // Counter restarts on every state change so each state needs its own full
  // stable run; it saturates instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if ((state_next != state) || !match) begin
      cnt <= '0;
    end else if (cnt != CNT_W'(DEBOUNCE_CYCLES)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

`ifdef AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                           REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_cnt;
  logic             rep_first;
  logic [REP_W-1:0] rep_target;

  // No repeat on the cycle the button leaves PRESSED.
  always_comb begin
    rep_target = rep_first ? REP_W'(REPEAT_DELAY_CYCLES - 1) : REP_W'(REPEAT_RATE_CYCLES - 1);
    rep_hit    = REPEAT_ALLOWED && (state == PRESSED) && (state_next == PRESSED) &&
                 (rep_cnt == rep_target);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (!REPEAT_ALLOWED || (state != PRESSED) || (state_next != PRESSED)) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (rep_hit) begin
      rep_cnt   <= '0;
      rep_first <= 1'b0;
    end else begin
      rep_cnt   <= rep_cnt + REP_W'(1);
    end
  end
`else
  // Repeat parameters stay on the interface but fold to a constant zero.
  always_comb begin
    rep_hit = 1'b0 & REPEAT_ALLOWED & (REPEAT_DELAY_CYCLES > 0) & (REPEAT_RATE_CYCLES > 0);
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) press_q <= 1'b0;
    else       press_q <= ((state == IDLE) && hit) || rep_hit;
  end

  always_comb begin
    nivel = (state == PRESSED);
    press = press_q;
  end

endmodule

// File: rtl/boton_acondicionador.sv
// rtl/boton_acondicionador.sv - five-button conditioner with one-hot press arbiter
// Purpose: debounces the five board buttons and serialises their press events
//          so at most one *_out pulses per clk (elige > arriba > abajo > izq > der).
//          Build macro: AUTOREPEAT_EN enables direction-button auto-repeat.
// Ports:   clk, reset (async, active-high), boton_*_in (raw buttons),
//          boton_*_out (one-clk press pulses), nivel_out (debounced levels
//          {elige,der,izq,abajo,arriba}).
import boton_acondicionador_pkg::*;

module boton_acondicionador #(
  parameter int DEBOUNCE_CYCLES     = 1000000,
  parameter int REPEAT_DELAY_CYCLES = 50000000,
  parameter int REPEAT_RATE_CYCLES  = 15000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       boton_arriba_in,
  input  logic       boton_abajo_in,
  input  logic       boton_izq_in,
  input  logic       boton_der_in,
  input  logic       boton_elige_in,
  output logic       boton_arriba_out,
  output logic       boton_abajo_out,
  output logic       boton_izq_out,
  output logic       boton_der_out,
  output logic       boton_elige_out,
  output logic [4:0] nivel_out
);

  logic [4:0] raw, nivel, press, pending, grant;

  assign raw = {boton_elige_in, boton_der_in, boton_izq_in, boton_abajo_in, boton_arriba_in};

  for (genvar i = 0; i < NUM_BOTONES; i++) begin : g_btn
    boton_debounce_fsm #(
      .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES),
      .REPEAT_ALLOWED     (1'(i != IDX_ELIGE))
    ) u_btn (
      .clk  (clk),
      .reset(reset),
      .boton(raw[i]),
      .nivel(nivel[i]),
      .press(press[i])
    );
  end

  assign grant = grant_of(pending);

  // A new event for the bit being granted this cycle keeps it pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= (pending & ~grant) | press;
  end

  assign boton_arriba_out = grant[IDX_ARRIBA];
  assign boton_abajo_out  = grant[IDX_ABAJO];
  assign boton_izq_out    = grant[IDX_IZQ];
  assign boton_der_out    = grant[IDX_DER];
  assign boton_elige_out  = grant[IDX_ELIGE];
  assign nivel_out        = nivel;

endmodule

// File: tb/tb_boton_acondicionador.sv
// tb/tb_boton_acondicionador.sv - self-checking bench for boton_acondicionador
module tb_boton_acondicionador;

  localparam int D     = 4;
  localparam int DELAY = 20;
  localparam int RATE  = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] btn_in = '0;
  logic       arriba_o, abajo_o, izq_o, der_o, elige_o;
  logic [4:0] nivel_o;
  logic [4:0] dut_out;

  assign dut_out = {elige_o, der_o, izq_o, abajo_o, arriba_o};

  always #5 clk = ~clk;

  boton_acondicionador #(
    .DEBOUNCE_CYCLES(D), .REPEAT_DELAY_CYCLES(DELAY), .REPEAT_RATE_CYCLES(RATE)
  ) dut (
    .clk(clk), .reset(reset),
    .boton_arriba_in(btn_in[0]), .boton_abajo_in(btn_in[1]), .boton_izq_in(btn_in[2]),
    .boton_der_in(btn_in[3]), .boton_elige_in(btn_in[4]),
    .boton_arriba_out(arriba_o), .boton_abajo_out(abajo_o), .boton_izq_out(izq_o),
    .boton_der_out(der_o), .boton_elige_out(elige_o), .nivel_out(nivel_o)
  );

  int compared = 0;
  int mismatched = 0;

  // Reference model: accepted level changes after D consecutive synchronized
  // samples of the opposite level since the last change; presses feed a
  // pending set served in priority order.
  bit [4:0] raw_hist[$];
  int       m_state[5];   // 0 waiting release after reset, 1 released, 2 held
  int       m_entry[5];
  bit [4:0] m_pending, m_ev;
  int       cyc;
  int       prio[5] = '{4, 0, 1, 2, 3};

  function automatic bit [4:0] ref_grant(bit [4:0] p);
    for (int k = 0; k < 5; k++) if (p[prio[k]]) return 5'b00001 << prio[k];
    return 5'b0;
  endfunction

  function automatic bit sync_at(int b, int c);
    if (c < 2) return 1'b0;
    return raw_hist[c-2][b];
  endfunction

  function automatic bit [4:0] exp_level();
    bit [4:0] l;
    for (int b = 0; b < 5; b++) l[b] = (m_state[b] == 2);
    return l;
  endfunction

  task automatic model_reset();
    raw_hist.delete();
    for (int b = 0; b < 5; b++) begin m_state[b] = 0; m_entry[b] = 0; end
    m_pending = '0;
    m_ev = '0;
    cyc = 0;
  endtask

  task automatic model_step();
    bit [4:0] new_ev;
    int t;
    bit stable, target;
    raw_hist.push_back(btn_in);
    t = cyc + 1;
    m_pending = (m_pending & ~ref_grant(m_pending)) | m_ev;
    new_ev = '0;
    for (int b = 0; b < 5; b++) begin
      target = (m_state[b] == 1);
      stable = (t - D >= m_entry[b]);
      for (int c = t - D; c < t; c++) if (stable && sync_at(b, c) != target) stable = 0;
      if (stable) begin
        if (m_state[b] == 1) begin m_state[b] = 2; new_ev[b] = 1; end
        else m_state[b] = 1;
        m_entry[b] = t;
      end
`ifdef AUTOREPEAT_EN
      else if (m_state[b] == 2 && b != 4) begin
        if ((t - m_entry[b] >= DELAY) && ((t - m_entry[b] - DELAY) % RATE == 0)) new_ev[b] = 1;
      end
`endif
    end
    m_ev = new_ev;
    cyc = t;
  endtask

  task automatic check(string name, logic [4:0] act, logic [4:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_step();
    #1;
    check("model_out", dut_out, ref_grant(m_pending));
    check("model_nivel", nivel_o, exp_level());
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    repeat (3) tick();
    check("reset_out", dut_out, 5'b0);
    check("reset_nivel", nivel_o, 5'b0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    string      name;
    logic [4:0] drive;
    int         adv;
    logic [4:0] exp_out;
    logic [4:0] exp_lvl;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int pulses, found, seg_len;
    int got[$];
    int exp_rep[6] = '{1, 21, 29, 37, 45, 53};

    vecs.push_back('{"armed_idle",    5'b00000, 10, 5'b00000, 5'b00000});
    vecs.push_back('{"arriba_wait",   5'b00001,  6, 5'b00000, 5'b00001});
    vecs.push_back('{"arriba_pulse",  5'b00001,  1, 5'b00001, 5'b00001});
    vecs.push_back('{"arriba_after",  5'b00001,  1, 5'b00000, 5'b00001});
    vecs.push_back('{"arriba_relhld", 5'b00000,  5, 5'b00000, 5'b00001});
    vecs.push_back('{"arriba_rel",    5'b00000,  1, 5'b00000, 5'b00000});
    vecs.push_back('{"bounce_h1",     5'b00010,  1, 5'b00000, 5'b00000});
    vecs.push_back('{"bounce_l1",     5'b00000,  1, 5'b00000, 5'b00000});
    vecs.push_back('{"bounce_h2",     5'b00010,  1, 5'b00000, 5'b00000});
    vecs.push_back('{"bounce_l2",     5'b00000,  1, 5'b00000, 5'b00000});
    vecs.push_back('{"abajo_wait",    5'b00010,  6, 5'b00000, 5'b00010});
    vecs.push_back('{"abajo_pulse",   5'b00010,  1, 5'b00010, 5'b00010});
    vecs.push_back('{"abajo_rel",     5'b00000,  8, 5'b00000, 5'b00000});
    vecs.push_back('{"both_wait",     5'b11000,  6, 5'b00000, 5'b11000});
    vecs.push_back('{"elige_first",   5'b11000,  1, 5'b10000, 5'b11000});
    vecs.push_back('{"der_second",    5'b11000,  1, 5'b01000, 5'b11000});
    vecs.push_back('{"both_quiet",    5'b11000,  1, 5'b00000, 5'b11000});
    vecs.push_back('{"both_rel",      5'b00000,  8, 5'b00000, 5'b00000});

    btn_in = '0;
    do_reset();
    foreach (vecs[i]) begin
      btn_in = vecs[i].drive;
      repeat (vecs[i].adv) tick();
      check({vecs[i].name, "_out"}, dut_out, vecs[i].exp_out);
      check({vecs[i].name, "_nivel"}, nivel_o, vecs[i].exp_lvl);
    end

    // izq held through reset: silent until released and pressed again
    btn_in = 5'b00100;
    do_reset();
    pulses = 0;
    repeat (20) begin tick(); pulses += int'(izq_o); end
    check_int("held_reset_no_pulse", pulses, 0);
    check("held_reset_nivel", nivel_o, 5'b0);
    btn_in = 5'b0;
    repeat (8) tick();
    btn_in = 5'b00100;
    pulses = 0;
    repeat (12) begin tick(); pulses += int'(izq_o); end
    check_int("repress_one_pulse", pulses, 1);
    btn_in = 5'b0;
    repeat (8) tick();

    // reset while der is still pending behind elige
    btn_in = 5'b11000;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin tick(); found = int'(elige_o); end
    check_int("midop_elige_seen", found, 1);
    reset = 1'b1;
    model_reset();
    #1;
    check("midop_reset_out", dut_out, 5'b0);
    check("midop_reset_nivel", nivel_o, 5'b0);
    repeat (2) tick();
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (20) begin tick(); pulses += int'(dut_out != 0); end
    check_int("midop_no_pulse", pulses, 0);
    check("midop_out_zero", dut_out, 5'b0);
    btn_in = 5'b0;
    repeat (8) tick();

`ifdef AUTOREPEAT_EN
    btn_in = 5'b00001;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin tick(); found = int'(nivel_o[0]); end
    check_int("rep_accept_seen", found, 1);
    for (int k = 1; k <= 60; k++) begin tick(); if (arriba_o) got.push_back(k); end
    check_int("rep_count", got.size(), 6);
    for (int i = 0; i < 6 && i < got.size(); i++) check_int("rep_offset", got[i], exp_rep[i]);
    btn_in = 5'b0;
    repeat (10) tick();
    btn_in = 5'b10000;
    pulses = 0;
    repeat (70) begin tick(); pulses += int'(elige_o); end
    check_int("elige_no_repeat", pulses, 1);
    btn_in = 5'b0;
    repeat (10) tick();
`endif

    // random segments checked cycle by cycle against the model
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 49) == 0) do_reset();
      btn_in = 5'($urandom);
      seg_len = $urandom_range(1, 10);
      repeat (seg_len) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
